// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared tile types and playfield geometry for the tank game
package tank_pkg;

    typedef enum logic [2:0] {
        EMPTY = 3'd0,
        BRICK = 3'd1,
        STEEL = 3'd2,
        WATER = 3'd3,
        TREE  = 3'd4,
        ICE   = 3'd5,
        BASE  = 3'd6
    } tile_t;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } init_state_t;

    localparam int MAP_W_DEFAULT = 13;
    localparam int MAP_H_DEFAULT = 13;
    localparam int TILE_PX       = 16;
    localparam int FIELD_PX      = 208;

    localparam logic [4:0] PAL_TRANSPARENT = 5'd0;

endpackage

// File: rtl/tile_sprite_rom.sv
// rtl/tile_sprite_rom.sv - combinational texel lookup across all tile sprites
module tile_sprite_rom
    import tank_pkg::*;
(
    input  logic [2:0] tile,
    input  logic [3:0] row,
    input  logic [3:0] col,
    output logic [4:0] idx
);

    logic [4:0] brick_rgb [0:15][0:15];
    logic [4:0] steel_rgb [0:15][0:15];
    logic [4:0] water_rgb [0:15][0:15];
    logic [4:0] tree_rgb  [0:15][0:15];
    logic [4:0] ice_rgb   [0:15][0:15];
    logic [4:0] base_rgb  [0:15][0:15];

    tile_brick u_brick (.rgb(brick_rgb));
    tile_steel u_steel (.rgb(steel_rgb));
    tile_water u_water (.rgb(water_rgb));
    tile_tree  u_tree  (.rgb(tree_rgb));
    tile_ice   u_ice   (.rgb(ice_rgb));
    tile_base  u_base  (.rgb(base_rgb));

    always_comb begin
        idx = PAL_TRANSPARENT;
        case (tile)
            BRICK:   idx = brick_rgb[row][col];
            STEEL:   idx = steel_rgb[row][col];
            WATER:   idx = water_rgb[row][col];
            TREE:    idx = tree_rgb[row][col];
            ICE:     idx = ice_rgb[row][col];
            BASE:    idx = base_rgb[row][col];
            default: idx = PAL_TRANSPARENT;
        endcase
    end

endmodule

// File: rtl/tile_sprites.sv
// rtl/tile_sprites.sv - 16x16 palette-index sprite ROMs for each solid tile type

module tile_brick (
    output logic [4:0] rgb [0:15][0:15]
);
    // Running-bond courses four texels tall, joints offset every other course
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = (r % 4 == 3) ? 5'd7 :
                               (((r / 4) % 2 == 0) ? (c % 8 == 7) : (c % 8 == 3)) ? 5'd7 : 5'd8;
        end
    end
endmodule

module tile_steel (
    output logic [4:0] rgb [0:15][0:15]
);
    // Four 8x8 plates: dark top/left rim, light bottom/right rim
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = (r % 8 == 0 || c % 8 == 0) ? 5'd4 :
                               (r % 8 == 7 || c % 8 == 7) ? 5'd6 : 5'd5;
        end
    end
endmodule

module tile_water (
    output logic [4:0] rgb [0:15][0:15]
);
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = ((r + c) % 4 == 0) ? 5'd9 : 5'd10;
        end
    end
endmodule

module tile_tree (
    output logic [4:0] rgb [0:15][0:15]
);
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = ((r ^ c) % 2 == 1) ? 5'd11 : 5'd12;
        end
    end
endmodule

module tile_ice (
    output logic [4:0] rgb [0:15][0:15]
);
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = (r == c) ? 5'd13 : 5'd14;
        end
    end
endmodule

module tile_base (
    output logic [4:0] rgb [0:15][0:15]
);
    for (genvar r = 0; r < 16; r++) begin : g_row
        for (genvar c = 0; c < 16; c++) begin : g_col
            assign rgb[r][c] = (r == 0 || r == 15 || c == 0 || c == 15) ? 5'd15 : 5'd16;
        end
    end
endmodule

// File: rtl/tile_layer_renderer.sv
// rtl/tile_layer_renderer.sv - tile map storage, collision query and 3-stage background pixel pipeline
module tile_layer_renderer
    import tank_pkg::*;
#(
    parameter int MAP_W    = MAP_W_DEFAULT,
    parameter int MAP_H    = MAP_H_DEFAULT,
    parameter int ORIGIN_X = 32,
    parameter int ORIGIN_Y = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       de,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [3:0] wr_x,
    input  logic [3:0] wr_y,
    input  logic [2:0] wr_tile,
    input  logic [3:0] q_x,
    input  logic [3:0] q_y,
    output logic [2:0] q_tile,
    output logic       init_done,
    output logic [4:0] pix_idx,
    output logic       pix_opaque,
    output logic       pix_de
);

    localparam int MAP_N = MAP_W * MAP_H;

    function automatic logic [7:0] addr_of(input logic [3:0] y, input logic [3:0] x);
        return 8'(y) * 8'(MAP_W) + 8'(x);
    endfunction

    init_state_t state, state_n;
    logic [7:0]  clr_addr, clr_addr_n;
    logic [2:0]  map_mem [0:MAP_N-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_INIT;
            clr_addr  <= 8'd0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            clr_addr  <= clr_addr_n;
            init_done <= (state == ST_IDLE);
        end
    end

    always_comb begin
        state_n    = state;
        clr_addr_n = clr_addr;
        if (state == ST_INIT) begin
            clr_addr_n = clr_addr + 8'd1;
            if (clr_addr == 8'(MAP_N - 1))
                state_n = ST_IDLE;
        end
    end

    assign wr_ready = init_done;

    logic wr_in_range;
    assign wr_in_range = (wr_x < 4'(MAP_W)) && (wr_y < 4'(MAP_H));

    // Off-map writes still complete the handshake; they simply never reach storage
    always_ff @(posedge clk) begin
        if (state == ST_INIT)
            map_mem[clr_addr] <= EMPTY;
        else if (wr_valid && wr_ready && wr_in_range)
            map_mem[addr_of(wr_y, wr_x)] <= wr_tile;
    end

    // Out-of-map queries report STEEL so movement logic sees a solid border
    always_ff @(posedge clk) begin
        if (reset)
            q_tile <= EMPTY;
        else if (q_x >= 4'(MAP_W) || q_y >= 4'(MAP_H))
            q_tile <= STEEL;
        else
            q_tile <= map_mem[addr_of(q_y, q_x)];
    end

    // Negative offsets wrap to large unsigned values, so one compare bounds both sides
    logic [10:0] fx, fy;
    logic        in_field;
    assign fx       = {1'b0, hcount} - 11'(ORIGIN_X);
    assign fy       = {1'b0, vcount} - 11'(ORIGIN_Y);
    assign in_field = de && (fx < 11'(MAP_W * TILE_PX)) && (fy < 11'(MAP_H * TILE_PX));

    logic [3:0] s1_col, s1_row, s1_tr, s1_tc;
    logic       s1_in, s1_de;
    logic [2:0] s2_tile;
    logic [3:0] s2_tr, s2_tc;
    logic       s2_in, s2_de;
    logic [4:0] rom_idx;
    logic       opaque;

    tile_sprite_rom u_rom (
        .tile (s2_tile),
        .row  (s2_tr),
        .col  (s2_tc),
        .idx  (rom_idx)
    );

    assign opaque = s2_in && init_done && (s2_tile != EMPTY) && (s2_tile != 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_col     <= 4'd0;
            s1_row     <= 4'd0;
            s1_tr      <= 4'd0;
            s1_tc      <= 4'd0;
            s1_in      <= 1'b0;
            s1_de      <= 1'b0;
            s2_tile    <= EMPTY;
            s2_tr      <= 4'd0;
            s2_tc      <= 4'd0;
            s2_in      <= 1'b0;
            s2_de      <= 1'b0;
            pix_idx    <= PAL_TRANSPARENT;
            pix_opaque <= 1'b0;
            pix_de     <= 1'b0;
        end else begin
            s1_col     <= fx[7:4];
            s1_row     <= fy[7:4];
            s1_tr      <= fy[3:0];
            s1_tc      <= fx[3:0];
            s1_in      <= in_field;
            s1_de      <= de;
            s2_tile    <= s1_in ? map_mem[addr_of(s1_row, s1_col)] : EMPTY;
            s2_tr      <= s1_tr;
            s2_tc      <= s1_tc;
            s2_in      <= s1_in;
            s2_de      <= s1_de;
            pix_idx    <= opaque ? rom_idx : PAL_TRANSPARENT;
            pix_opaque <= opaque;
            pix_de     <= s2_de;
        end
    end

endmodule

// File: doc/tile_layer_renderer.md
# tile_layer_renderer

Per-pixel background renderer for the 13×13-tile playfield. It holds the tile map, written by game logic over a valid/ready port and readable through a one-cycle collision query port. For each VGA pixel it looks up the tile under the beam and the matching 16×16 sprite texel, and emits a 5-bit palette index to the compositor/palette stage. It sits directly downstream of the tile sprite ROMs (steel, brick, water, …) and consumes their `rgb[0:15][0:15]` palette-index arrays.

## Interface
- `MAP_W`, 13: tiles per row.
- `MAP_H`, 13: tiles per column.
- `ORIGIN_X`, 32: screen x of the playfield's left edge, in pixels.
- `ORIGIN_Y`, 16: screen y of the playfield's top edge, in pixels.
- `clk` in 1: pixel clock; the block's only clock.
- `reset` in 1: synchronous, active-high.
- `hcount` in 10: beam x.
- `vcount` in 10: beam y.
- `de` in 1: display enable for this pixel.
- `wr_valid` in 1: tile write request.
- `wr_ready` out 1: high only in IDLE.
- `wr_x` in 4: tile column of the write.
- `wr_y` in 4: tile row of the write.
- `wr_tile` in 3: `tile_t` value to write.
- `q_x` in 4: query tile column.
- `q_y` in 4: query tile row.
- `q_tile` out 3: tile at the query coordinates, registered.
- `init_done` out 1: map clear complete.
- `pix_idx` out 5: palette index.
- `pix_opaque` out 1: 1 means the compositor uses `pix_idx`; 0 means transparent.
- `pix_de` out 1: `de` delayed to align with the pixel outputs.

## Operation
- **Tile types (`tile_t`):**
  - EMPTY=0, BRICK=1, STEEL=2, WATER=3, TREE=4, ICE=5, BASE=6.
  - Code 7 is reserved and renders as EMPTY.
- **Map storage:** register array of MAP_W·MAP_H entries.
  - Address = y·MAP_W + x.
  - One write port and two asynchronous-read ports (render and query), each read registered at its consumer.
- **Init FSM:** two states, INIT and IDLE.
  - `reset` enters INIT and sets `clr_addr` to 0.
  - INIT writes EMPTY to `clr_addr` each cycle and increments it. After writing address 168, the FSM moves to IDLE.
  - IDLE never returns to INIT except via `reset`.
  - `init_done` = (state == IDLE), registered. `wr_ready` equals `init_done`.
- **Write handshake:** a write is accepted on a cycle where `wr_valid` and `wr_ready` are both high.
  - If `wr_x` ≥ 13 or `wr_y` ≥ 13, the handshake completes but the map is unchanged.
  - While `wr_ready` = 0, `wr_valid` is ignored. The requester holds its request.
- **Query:** `q_tile` is registered and equals map[`q_y`][`q_x`] as of the previous cycle.
  - If either coordinate is ≥ 13, `q_tile` = STEEL, so the outer boundary is solid.
  - When a write and a query hit the same address in the same cycle, the query returns the old value (read-before-write).
- **Render pipeline:** three stages.
  - **S1:** `fx` = `hcount` − ORIGIN_X and `fy` = `vcount` − ORIGIN_Y, as 11-bit signed values. `in_field` = `de` & 0≤`fx`<208 & 0≤`fy`<208. Register `tile col` = `fx[7:4]`, `tile row` = `fy[7:4]`, texel (`fy[3:0]`, `fx[3:0]`), `in_field` and `de`.
  - **S2:** register the map entry for (row, col), plus the texel coordinates and flags.
  - **S3:** `tile_sprite_rom` maps (type, texel row, texel col) to an index. Register `pix_idx`, `pix_opaque` and `pix_de`.
- **Opacity:**
  - `pix_opaque` = `in_field` & `init_done` & type ∉ {EMPTY, 7}.
  - When not opaque, `pix_idx` = 0.
  - TREE is opaque in this layer. Overlay priority over tanks is the compositor's responsibility.

## Timing
- **Reset values:**
  - `pix_idx` = 0, `pix_opaque` = 0, `pix_de` = 0.
  - `q_tile` = EMPTY.
  - `init_done` = 0, `wr_ready` = 0.
  - All pipeline registers cleared.
- **Init:** with `reset` deasserted at cycle 0, `init_done` and `wr_ready` are first high in cycle 169.
- **Reset mid-INIT:** restarts the clear from address 0 and takes the full 169 cycles again.
- **Render latency:** exactly 3 cycles from `hcount`/`vcount`/`de` to the outputs, at one pixel per cycle with no stalls.
- **Write visibility:**
  - A write accepted in cycle N is visible to the query read in cycle N+1 (`q_tile` at N+2).
  - It is visible to a render S2 read in cycle N+1.
- **`init_done` gating:** uses the registered `init_done`. At most one pixel in flight at the INIT→IDLE edge renders transparent. This is acceptable.

## Structure
- **`tank_pkg`** holds:
  - `tile_t` enum;
  - MAP_W and MAP_H defaults;
  - TILE_PX = 16;
  - FIELD_PX = 208;
  - `PAL_TRANSPARENT` = 5'd0.
- **Sub-module `tile_sprite_rom`:**
  - Instantiates the per-tile sprite modules (brick, steel, water, tree, ice, base).
  - Muxes their arrays by `tile_t`, texel row and texel col, combinationally.
  - Returns 5'd0 for EMPTY and reserved types.
- **Top level:** the FSM, the map array, the query port and the pipeline registers.

## Test plan
- **Reset and init:** release `reset` at cycle 0 → `wr_ready`/`init_done` = 0 through cycle 168 and 1 at cycle 169. A query of (5,5) then returns EMPTY.
- **Steel texel:** write STEEL at (0,0). Drive `hcount`=34, `vcount`=18, `de`=1 → 3 cycles later `pix_idx`=5, `pix_opaque`=1, `pix_de`=1. Move to `hcount`=32, `vcount`=16 → `pix_idx`=4.
- **Transparency and bounds:**
  - `hcount`=31 with any tile → `pix_opaque`=0 and `pix_idx`=0.
  - `hcount`=240 (`fx`=208) → transparent.
  - An EMPTY tile in the field → transparent.
- **Query edges:**
  - `q_x`=13, `q_y`=0 → `q_tile`=STEEL.
  - A write of BRICK to (3,4) and a query of (3,4) in the same cycle → `q_tile`=EMPTY. The following cycle's query of (3,4) → BRICK.
- **Reset mid-INIT:** assert `reset` at cycle 80 of INIT → `init_done` stays low and rises 169 cycles after release. `wr_valid` held high during INIT writes nothing until `wr_ready`.
- **Out-of-range write:** `wr_x`=14 accepted in one cycle → the map is unchanged, verified by sweeping queries over all 169 entries.
